// File: rtl/uram_par_grid_if.sv
// Port bundle for uram_par_grid: write port A, read port B and the read response.
interface uram_par_grid_if #(
  parameter int WIDTH  = 128,
  parameter int N_COLS = 2,
  parameter int AW     = 13
);
  logic              weA;
  logic              enA;
  logic [AW-1:0]     addrA;
  logic [WIDTH-1:0]  dinA;
  logic [N_COLS-1:0] wmaskA;
  logic              enB;
  logic [AW-1:0]     addrB;
  logic [WIDTH-1:0]  doutB;
  logic              validB;
  logic              oobB;

  modport master (output weA, enA, addrA, dinA, wmaskA, enB, addrB,
                  input  doutB, validB, oobB);
  modport slave  (input  weA, enA, addrA, dinA, wmaskA, enB, addrB,
                  output doutB, validB, oobB);
endinterface

// File: rtl/uram_par_grid.sv
// Simple dual-port memory tiled as a rows x cols grid of URAM-sized blocks.
// Optional macro URAM_PAR_GRID_FWD_EN: forward masked write data on same-address collisions.
module uram_par_grid #(
  parameter int WIDTH     = 128,
  parameter int DEPTH     = 8192,
  parameter int COL_WIDTH = 64,
  parameter int ROW_DEPTH = 4096,
  parameter int RD_LAT    = 2
) (
  input  logic          clk,
  input  logic          rst,
  uram_par_grid_if.slave bus
);
  localparam int N_COLS = (WIDTH + COL_WIDTH - 1) / COL_WIDTH;
  localparam int N_ROWS = (DEPTH + ROW_DEPTH - 1) / ROW_DEPTH;
  localparam int RAW    = $clog2(ROW_DEPTH);
  localparam int RSW    = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam int NCW    = N_COLS * COL_WIDTH;

  logic            w_weA, w_acceptB, w_oobB, w_rdB;
  logic [RSW-1:0]  w_rowA, w_rowB;
  logic [RAW-1:0]  w_locA, w_locB;
  logic [NCW-1:0]  w_din;
  logic [N_ROWS-1:0][N_COLS-1:0][COL_WIDTH-1:0] w_rq;

  assign w_weA     = bus.enA & bus.weA & ~rst & (32'(bus.addrA) < DEPTH);
  assign w_oobB    = ~(32'(bus.addrB) < DEPTH);
  assign w_acceptB = bus.enB & ~rst;
  assign w_rdB     = w_acceptB & ~w_oobB;
  assign w_rowA    = (N_ROWS == 1) ? '0 : RSW'(32'(bus.addrA) >> RAW);
  assign w_rowB    = (N_ROWS == 1) ? '0 : RSW'(32'(bus.addrB) >> RAW);
  assign w_locA    = RAW'(bus.addrA);
  assign w_locB    = RAW'(bus.addrB);
  // Pad bits of the last column are written as zero and never reach doutB.
  assign w_din     = NCW'(bus.dinA);

`ifdef URAM_PAR_GRID_FWD_EN
  logic w_coll;
  assign w_coll = w_weA & w_rdB & (bus.addrA == bus.addrB);
`endif

  for (genvar r = 0; r < N_ROWS; r++) begin : g_row
    for (genvar c = 0; c < N_COLS; c++) begin : g_col
      logic [COL_WIDTH-1:0] r_mem [ROW_DEPTH];
      logic [COL_WIDTH-1:0] r_q;

      // Read and write in one block: the read sees the pre-write word (read-first).
      always_ff @(posedge clk) begin
        if (w_weA && w_rowA == RSW'(r) && bus.wmaskA[c])
          r_mem[w_locA] <= w_din[c*COL_WIDTH +: COL_WIDTH];
        if (w_rdB && w_rowB == RSW'(r))
`ifdef URAM_PAR_GRID_FWD_EN
          r_q <= (w_coll && bus.wmaskA[c]) ? w_din[c*COL_WIDTH +: COL_WIDTH] : r_mem[w_locB];
`else
          r_q <= r_mem[w_locB];
`endif
      end
      assign w_rq[r][c] = r_q;
    end
  end

  logic [RD_LAT:1] r_vld_pipe, r_oob_pipe;
  logic [RSW-1:0]  r_row1;
  logic [NCW-1:0]  w_d1, w_dout_raw;
  logic [WIDTH-1:0] r_hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_pipe <= '0;
      r_oob_pipe <= '0;
      r_row1     <= '0;
    end else begin
      r_vld_pipe[1] <= w_acceptB;
      r_oob_pipe[1] <= w_acceptB & w_oobB;
      r_row1        <= w_rowB;
      for (int k = 2; k <= RD_LAT; k++) begin
        r_vld_pipe[k] <= r_vld_pipe[k-1];
        r_oob_pipe[k] <= r_oob_pipe[k-1];
      end
    end
  end

  // Row mux sits right at the URAM output, keyed by the row of the same request.
  assign w_d1 = r_oob_pipe[1] ? '0 : w_rq[r_row1];

  if (RD_LAT == 1) begin : g_noreg
    assign w_dout_raw = w_d1;
  end else begin : g_oreg
    logic [RD_LAT-2:0][NCW-1:0] r_oreg;
    always_ff @(posedge clk) begin
      if (rst) r_oreg <= '0;
      else begin
        r_oreg[0] <= w_d1;
        for (int k = 1; k <= RD_LAT-2; k++) r_oreg[k] <= r_oreg[k-1];
      end
    end
    assign w_dout_raw = r_oreg[RD_LAT-2];
  end

  always_ff @(posedge clk) begin
    if (rst)                     r_hold <= '0;
    else if (r_vld_pipe[RD_LAT]) r_hold <= w_dout_raw[WIDTH-1:0];
  end

  assign bus.validB = r_vld_pipe[RD_LAT];
  assign bus.oobB   = r_vld_pipe[RD_LAT] & r_oob_pipe[RD_LAT];
  assign bus.doutB  = r_vld_pipe[RD_LAT] ? w_dout_raw[WIDTH-1:0] : r_hold;
endmodule

// File: tb/tb_uram_par_grid.sv
// Directed bench: a 128x8192 RD_LAT=2 instance and a 72x6000 RD_LAT=4 instance.
module tb_uram_par_grid;
  logic clk = 1'b0;
  logic rst0, rst1;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  uram_par_grid_if #(.WIDTH(128), .N_COLS(2), .AW(13)) if0 ();
  uram_par_grid_if #(.WIDTH(72),  .N_COLS(2), .AW(13)) if1 ();

  uram_par_grid #(.WIDTH(128), .DEPTH(8192), .COL_WIDTH(64), .ROW_DEPTH(4096), .RD_LAT(2))
    dut0 (.clk(clk), .rst(rst0), .bus(if0.slave));
  uram_par_grid #(.WIDTH(72), .DEPTH(6000), .COL_WIDTH(64), .ROW_DEPTH(4096), .RD_LAT(4))
    dut1 (.clk(clk), .rst(rst1), .bus(if1.slave));

  localparam logic [127:0] PA5  = {16{8'hA5}};
  localparam logic [127:0] P5A  = {16{8'h5A}};
  localparam logic [127:0] P11  = {16{8'h11}};
  localparam logic [127:0] PFF  = {16{8'hFF}};
  localparam logic [71:0]  ONES72 = 72'hFF_FFFF_FFFF_FFFF_FFFF;
  localparam logic [71:0]  PAT72  = 72'h3C_0123_4567_89AB_CDEF;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle0();
    if0.enA = 0; if0.weA = 0; if0.enB = 0;
  endtask

  task automatic idle1();
    if1.enA = 0; if1.weA = 0; if1.enB = 0;
  endtask

  task automatic wr0(input int a, input logic [127:0] d, input logic [1:0] m);
    if0.enA = 1; if0.weA = 1; if0.addrA = 13'(a); if0.dinA = d; if0.wmaskA = m;
  endtask

  task automatic wr1(input int a, input logic [71:0] d, input logic [1:0] m);
    if1.enA = 1; if1.weA = 1; if1.addrA = 13'(a); if1.dinA = d; if1.wmaskA = m;
  endtask

  initial begin
    rst0 = 1; rst1 = 1;
    if0.addrA = '0; if0.dinA = '0; if0.wmaskA = '0; if0.addrB = '0;
    if1.addrA = '0; if1.dinA = '0; if1.wmaskA = '0; if1.addrB = '0;
    idle0(); idle1();
    tick(); tick();
    chk("rst0_valid", 128'(if0.validB), 0);
    chk("rst0_oob",   128'(if0.oobB),   0);
    chk("rst0_dout",  if0.doutB,        0);
    chk("rst1_valid", 128'(if1.validB), 0);
    chk("rst1_oob",   128'(if1.oobB),   0);
    chk("rst1_dout",  128'(if1.doutB),  0);
    rst0 = 0; rst1 = 0;
    tick();

    // Back-to-back reads from both grid rows.
    wr0(5, PA5, 2'b11);    tick();
    wr0(4100, P5A, 2'b11); tick();
    idle0(); if0.enB = 1; if0.addrB = 13'd5;    tick();
    chk("b2b_t1_valid", 128'(if0.validB), 0);
    if0.addrB = 13'd4100; tick();
    chk("b2b_t2_valid", 128'(if0.validB), 1);
    chk("b2b_t2_data",  if0.doutB, PA5);
    if0.enB = 0; tick();
    chk("b2b_t3_valid", 128'(if0.validB), 1);
    chk("b2b_t3_data",  if0.doutB, P5A);
    tick();
    chk("hold_valid", 128'(if0.validB), 0);
    chk("hold_data",  if0.doutB, P5A);

    // Per-column write mask.
    wr0(7, P11, 2'b11); tick();
    wr0(7, PFF, 2'b10); tick();
    idle0(); if0.enB = 1; if0.addrB = 13'd7; tick();
    if0.enB = 0; tick();
    chk("mask_data", if0.doutB, {64'hFFFF_FFFF_FFFF_FFFF, 64'h1111_1111_1111_1111});

    // Same-cycle collision: read-first.
    wr0(9, 128'h1, 2'b11); tick();
    wr0(9, 128'h2, 2'b11); if0.enB = 1; if0.addrB = 13'd9; tick();
    idle0(); tick();
    chk("coll_old", if0.doutB, 128'h1);
    if0.enB = 1; tick();
    if0.enB = 0; tick();
    chk("coll_after", if0.doutB, 128'h2);

    // 72-bit width, RD_LAT=4 exact latency.
    wr1(3, ONES72, 2'b11); tick();
    idle1(); if1.enB = 1; if1.addrB = 13'd3; tick();
    if1.enB = 0; tick(); tick();
    chk("w72_early", 128'(if1.validB), 0);
    tick();
    chk("w72_valid", 128'(if1.validB), 1);
    chk("w72_data",  128'(if1.doutB), 128'(ONES72));

    // Out-of-range write dropped, out-of-range read returns zero with oob.
    wr1(2904, PAT72, 2'b11); tick();
    wr1(7000, 72'h0, 2'b11); tick();
    idle1(); if1.enB = 1; if1.addrB = 13'd7000; tick();
    if1.addrB = 13'd2904; tick();
    if1.enB = 0; tick(); tick();
    chk("oob_valid", 128'(if1.validB), 1);
    chk("oob_flag",  128'(if1.oobB), 1);
    chk("oob_data",  128'(if1.doutB), 0);
    tick();
    chk("oob_next_flag", 128'(if1.oobB), 0);
    chk("alias_data",    128'(if1.doutB), 128'(PAT72));

    // Reset with a read in flight; a write during reset is ignored.
    if1.enB = 1; if1.addrB = 13'd3; tick();
    if1.enB = 0; rst1 = 1; wr1(3, 72'h0, 2'b11); tick();
    chk("rst_mid_dout", 128'(if1.doutB), 0);
    rst1 = 0; idle1(); tick();
    if1.enB = 1; if1.addrB = 13'd3; tick();
    chk("rst_stale_t4", 128'(if1.validB), 0);
    if1.enB = 0; tick();
    chk("rst_stale_t5", 128'(if1.validB), 0);
    tick();
    chk("rst_stale_t6", 128'(if1.validB), 0);
    tick();
    chk("rst_new_valid", 128'(if1.validB), 1);
    chk("rst_new_data",  128'(if1.doutB), 128'(ONES72));
    tick();
    chk("rst_new_single", 128'(if1.validB), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
